// File: rtl/uart_tx_fifo_periph.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, a status register and
// a control register. Every bus access is acknowledged one cycle after it is
// accepted.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, waiting for tx_enable and a non-empty FIFO
// START | start bit (low) for DIV cycles
// DATA  | eight data bits, LSB first, DIV cycles each
// STOP  | stop bit (high) for DIV cycles, then one IDLE cycle
module uart_tx_fifo_periph #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        uart_tx
);

  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LOAD = BW'(DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          tx_enable;

  logic          accept;
  logic          is_write;
  logic [1:0]    reg_sel;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ctrl_wr;
  logic          flush;
  logic          full;
  logic          empty;
  logic [7:0]    count8;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  assign accept   = mem_valid && !mem_ready;
  assign is_write = |mem_wstrb;
  assign reg_sel  = mem_addr[3:2];
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign push_req = accept && is_write && mem_wstrb[0] && (reg_sel == 2'd0);
  assign ctrl_wr  = accept && is_write && mem_wstrb[0] && (reg_sel == 2'd2);
  assign flush    = ctrl_wr && mem_wdata[1];
  // full is the pre-edge value, so a write while full is dropped even if the
  // transmitter pops on the same edge
  assign push     = push_req && !full && !flush;
  assign pop      = (state == IDLE) && tx_enable && !empty;
  assign count8   = 8'(count);

  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8]};

  // read mux over the pre-edge register state
  always_comb begin
    rd_mux = 32'h0;
    case (reg_sel)
      2'd1:    rd_mux = {16'h0, count8, 4'h0, overflow, empty, full, state != IDLE};
      2'd2:    rd_mux = {31'h0, tx_enable};
      default: rd_mux = 32'h0;
    endcase
  end

  // fixed one-cycle acknowledge; read data is captured at the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !is_write) ? rd_mux : 32'h0;
    end
  end

  // control bits and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_enable <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      if (ctrl_wr) tx_enable <= mem_wdata[0];
      if (ctrl_wr && mem_wdata[2]) overflow <= 1'b0;
      else if (push_req && full)   overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; flush beats any same-edge push
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // FIFO storage; emptiness is tracked by count so no reset is needed here
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  // transmit FSM with registered serial output
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= fifo_mem[rd_ptr];
            baud_cnt <= BAUD_LOAD;
            uart_tx  <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= '0;
            uart_tx  <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == '0) state <= IDLE;
          else                baud_cnt <= baud_cnt - BW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_periph.sv
// Bench for uart_tx_fifo_periph: register vectors from a table, hand-written
// frame/flush/reset sequences, and random bus traffic, all shadowed by a
// timestamp-based model of the FIFO and serial line.
module tb_uart_tx_fifo_periph;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV + 1;
  localparam logic [31:0] A_TX = 32'h8000_0000;
  localparam logic [31:0] A_ST = 32'h8000_0004;
  localparam logic [31:0] A_CT = 32'h8000_0008;
  localparam logic [31:0] A_RS = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        uart_tx;

  uart_tx_fifo_periph #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  function automatic logic [31:0] z(input logic x);
    return {31'h0, x};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_q[$];
  bit          m_en;
  bit          m_ovf;
  int          m_free;
  int          m_last_pop = -1000;
  logic [7:0]  m_byte;
  bit          m_ready;
  logic [31:0] m_rdata;
  bit          acc, wr, full_pre, do_pop;
  int          a, off, k;
  logic [2:0]  bi;
  logic        exp_tx;

  function automatic logic [31:0] status_word();
    return {16'h0, 8'(m_q.size()), 4'h0, m_ovf, m_q.size() == 0,
            m_q.size() == DEPTH, cyc < m_free};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_en       = 1'b1;
      m_ovf      = 1'b0;
      m_free     = cyc + 1;
      m_last_pop = -1000;
      m_ready    = 1'b0;
      m_rdata    = 32'h0;
    end else begin
      acc      = mem_valid && !m_ready;
      wr       = (mem_wstrb != 4'h0);
      a        = int'(mem_addr[3:2]);
      full_pre = (m_q.size() == DEPTH);
      do_pop   = m_en && (m_q.size() != 0) && (cyc >= m_free);
      m_rdata  = 32'h0;
      if (acc && !wr) begin
        if (a == 1)      m_rdata = status_word();
        else if (a == 2) m_rdata = {31'h0, m_en};
      end
      if (do_pop) begin
        m_byte     = m_q.pop_front();
        m_last_pop = cyc;
        m_free     = cyc + FRAME;
      end
      if (acc && wr && mem_wstrb[0]) begin
        if (a == 0) begin
          if (full_pre) m_ovf = 1'b1;
          else          m_q.push_back(mem_wdata[7:0]);
        end else if (a == 2) begin
          m_en = mem_wdata[0];
          if (mem_wdata[1]) m_q.delete();
          if (mem_wdata[2]) m_ovf = 1'b0;
        end
      end
      m_ready = acc;
    end
    #1;
    if (chk_en) begin
      off = cyc - m_last_pop;
      if (off >= 0 && off < 10 * DIV) begin
        k = off / DIV;
        if (k == 0)      exp_tx = 1'b0;
        else if (k == 9) exp_tx = 1'b1;
        else begin
          bi     = 3'(k - 1);
          exp_tx = m_byte[bi];
        end
      end else begin
        exp_tx = 1'b1;
      end
      check("model_uart_tx", z(uart_tx), z(exp_tx));
      check("model_mem_ready", z(mem_ready), z(m_ready));
      if (m_ready) check("model_mem_rdata", mem_rdata, m_rdata);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
    bit          chk;
    int          grp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int g, input logic [31:0] ad, input logic [31:0] wd,
                              input logic [3:0] st, input bit c, input logic [31:0] ex);
    vec_t v;
    v.grp = g; v.addr = ad; v.wdata = wd; v.strb = st; v.chk = c; v.exp = ex;
    return v;
  endfunction

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     output logic [31:0] rd, output int e0);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    @(posedge clk);
    #2;
    e0 = cyc;
    rd = mem_rdata;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic apply_group(input int g, output int last_e0);
    logic [31:0] rd;
    int e;
    last_e0 = 0;
    foreach (tbl[i]) begin
      if (tbl[i].grp == g) begin
        bus(tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, e);
        last_e0 = e;
        if (tbl[i].chk) check($sformatf("vec%0d_grp%0d", i, g), rd, tbl[i].exp);
      end
    end
  endtask

  // waits (bounded) for a start bit, then samples mid-bit
  task automatic rx_byte(input int budget, output int ts, output logic [7:0] b,
                         output bit ok, output logic stop_bit);
    ok = 1'b0; ts = 0; b = 8'h0; stop_bit = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #2;
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        ts = cyc;
      end
    end
    if (ok) begin
      repeat (DIV + DIV / 2) @(posedge clk);
      for (int j = 0; j < 8; j++) begin
        #2;
        b = {uart_tx, b[7:1]};
        repeat (DIV) @(posedge clk);
      end
      #2;
      stop_bit = uart_tx;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd, rd2, tmp;
  int          e0, e1, e2, ts, tprev;
  logic [7:0]  b, d55;
  bit          ok;
  logic        sb, exp1;
  int          off1, sel;
  logic [2:0]  bi1;
  logic [7:0]  exp_bytes [4];

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;

    tbl.push_back(mk(0, A_ST, 32'h0, 4'h0, 1, 32'h0000_0004));
    tbl.push_back(mk(0, A_CT, 32'h0, 4'h0, 1, 32'h0000_0001));
    tbl.push_back(mk(0, A_RS, 32'h0, 4'h0, 1, 32'h0000_0000));
    tbl.push_back(mk(1, A_CT, 32'h0, 4'hF, 0, 32'h0));
    tbl.push_back(mk(1, A_TX, 32'h01, 4'hF, 0, 32'h0));
    tbl.push_back(mk(1, A_TX, 32'h02, 4'hF, 0, 32'h0));
    tbl.push_back(mk(1, A_TX, 32'h03, 4'hF, 0, 32'h0));
    tbl.push_back(mk(1, A_TX, 32'h04, 4'hF, 0, 32'h0));
    tbl.push_back(mk(1, A_TX, 32'h05, 4'hF, 0, 32'h0));
    tbl.push_back(mk(1, A_ST, 32'h0, 4'h0, 1, 32'h0000_040A));
    tbl.push_back(mk(1, A_CT, 32'h0, 4'h0, 1, 32'h0000_0000));
    tbl.push_back(mk(1, A_CT, 32'h1, 4'hF, 0, 32'h0));
    tbl.push_back(mk(2, A_ST, 32'h0, 4'h0, 1, 32'h0000_000C));
    tbl.push_back(mk(2, A_CT, 32'h5, 4'hF, 0, 32'h0));
    tbl.push_back(mk(2, A_ST, 32'h0, 4'h0, 1, 32'h0000_0004));
    tbl.push_back(mk(2, A_CT, 32'h0, 4'h0, 1, 32'h0000_0001));
    tbl.push_back(mk(3, A_CT, 32'h0, 4'hF, 0, 32'h0));
    tbl.push_back(mk(3, A_TX, 32'h77, 4'hF, 0, 32'h0));
    tbl.push_back(mk(3, A_ST, 32'h0, 4'h0, 1, 32'h0000_0100));
    tbl.push_back(mk(3, A_TX, 32'h88, 4'b0010, 0, 32'h0));
    tbl.push_back(mk(3, A_ST, 32'h0, 4'h0, 1, 32'h0000_0100));
    tbl.push_back(mk(3, 32'hFFFF_F00C, 32'h0, 4'h0, 1, 32'h0000_0000));
    tbl.push_back(mk(3, A_TX, 32'h0, 4'h0, 1, 32'h0000_0000));
    tbl.push_back(mk(3, A_RS, 32'hFFFF_FFFF, 4'hF, 0, 32'h0));
    tbl.push_back(mk(3, A_ST, 32'hFFFF_FFFF, 4'hF, 0, 32'h0));
    tbl.push_back(mk(3, A_ST, 32'h0, 4'h0, 1, 32'h0000_0100));
    tbl.push_back(mk(3, A_CT, 32'h0, 4'h0, 1, 32'h0000_0000));
    tbl.push_back(mk(3, A_CT, 32'h3, 4'hF, 0, 32'h0));
    tbl.push_back(mk(3, A_ST, 32'h0, 4'h0, 1, 32'h0000_0004));
    tbl.push_back(mk(3, A_CT, 32'h0, 4'h0, 1, 32'h0000_0001));
    tbl.push_back(mk(4, A_ST, 32'h0, 4'h0, 1, 32'h0000_0004));
    tbl.push_back(mk(4, A_CT, 32'h0, 4'h0, 1, 32'h0000_0001));

    exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h02; exp_bytes[2] = 8'h03; exp_bytes[3] = 8'h04;

    // reset values
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_uart_tx", z(uart_tx), 32'h1);
    check("reset_mem_ready", z(mem_ready), 32'h0);
    check("reset_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    apply_group(0, e0);

    // single byte 0x55: exact line waveform and busy clearing
    d55 = 8'h55;
    bus(A_TX, 32'h55, 4'hF, rd, e0);
    check("s1_ready_after_e0", z(mem_ready), 32'h1);
    for (int kk = 1; kk <= 101; kk++) begin
      @(posedge clk);
      #2;
      if (kk == 1) check("s1_ready_drops", z(mem_ready), 32'h0);
      off1 = kk - 1;
      if (off1 < DIV) exp1 = 1'b0;
      else if (off1 < 9 * DIV) begin
        bi1  = 3'((off1 - DIV) / DIV);
        exp1 = d55[bi1];
      end else exp1 = 1'b1;
      check($sformatf("s1_line_e0+%0d", kk), z(uart_tx), z(exp1));
    end
    bus(A_ST, 32'h0, 4'h0, rd, e1);
    check("s1_status_idle", rd, 32'h0000_0004);

    // overflow with transmitter disabled, then drain 4 frames
    apply_group(1, e0);
    tprev = e0 + 1;
    for (int i = 0; i < 4; i++) begin
      rx_byte(200, ts, b, ok, sb);
      check($sformatf("s2_frame%0d_found", i), z(ok), 32'h1);
      if (ok) begin
        check($sformatf("s2_frame%0d_byte", i), {24'h0, b}, {24'h0, exp_bytes[i]});
        check($sformatf("s2_frame%0d_start", i), 32'(ts), 32'(tprev));
        check($sformatf("s2_frame%0d_stop", i), z(sb), 32'h1);
      end
      tprev = ts + FRAME;
    end
    rx_byte(300, ts, b, ok, sb);
    check("s2_no_fifth_frame", z(ok), 32'h0);
    apply_group(2, e0);

    // flush during the first frame's data phase
    bus(A_TX, 32'hA1, 4'hF, rd, e0);
    fork
      rx_byte(20, ts, b, ok, sb);
      begin
        bus(A_TX, 32'hA2, 4'hF, rd2, e2);
        bus(A_TX, 32'hA3, 4'hF, rd2, e2);
        repeat (30) @(negedge clk);
        bus(A_CT, 32'h3, 4'hF, rd2, e2);
        bus(A_ST, 32'h0, 4'h0, rd2, e2);
        check("s3_status_after_flush", rd2, 32'h0000_0005);
      end
    join
    check("s3_frame_found", z(ok), 32'h1);
    check("s3_frame_byte", {24'h0, b}, 32'h0000_00A1);
    check("s3_frame_start", 32'(ts), 32'(e0 + 1));
    rx_byte(300, ts, b, ok, sb);
    check("s3_no_more_frames", z(ok), 32'h0);
    bus(A_ST, 32'h0, 4'h0, rd, e1);
    check("s3_status_empty", rd, 32'h0000_0004);

    // reset during data bit 3 of 0xF0, with a request pending
    bus(A_TX, 32'hF0, 4'hF, rd, e0);
    repeat (43) @(negedge clk);
    check("s4_bit3_low", z(uart_tx), 32'h0);
    rst = 1'b1; mem_valid = 1'b1; mem_addr = A_ST; mem_wstrb = 4'h0;
    @(posedge clk);
    #2;
    check("s4_line_high_after_rst", z(uart_tx), 32'h1);
    check("s4_no_ack_in_rst", z(mem_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_valid = 1'b0;
    apply_group(4, e0);

    // register corner cases
    apply_group(3, e0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sel = int'($urandom_range(0, 9));
      tmp = $urandom();
      mem_addr  = {tmp[31:4], (sel < 6) ? 2'd0 : (sel < 8) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3, tmp[1:0]};
      mem_wdata = $urandom();
      mem_wstrb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if (sel == 8) begin
        mem_wdata[0] = ($urandom_range(0, 3) != 0);
        mem_wdata[1] = ($urandom_range(0, 15) == 0);
        mem_wdata[2] = ($urandom_range(0, 1) == 1);
      end
      mem_valid = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (50) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied, %0d miscompares", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
